// File: rtl/rr_arb_mux.sv
// Round-robin N:1 arbiter/multiplexer with packet locking.
// A grant is held from the first beat of a packet through its last beat.
module rr_arb_mux #(
  parameter int unsigned N     = 2,
  parameter int unsigned NBITS = 8,
  parameter int unsigned IDW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         in_valid,
  input  logic [N*NBITS-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [NBITS-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [N-1:0]         out_grant,
  output logic [IDW-1:0]       out_id
);

  logic [IDW-1:0] ptr, lk, g_id, ptr_nxt;
  logic           lock;
  logic [IDW-1:0] eff_ptr, eff_lk;
  logic           eff_lock;
  logic [N-1:0]   grant;
  logic           has_grant;
  logic           xfer;

  // While resetn is low the outputs already behave as if the state were cleared.
  assign eff_lock = resetn & lock;
  assign eff_ptr  = resetn ? ptr : '0;
  assign eff_lk   = resetn ? lk  : '0;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    g_id      = '0;
    has_grant = 1'b0;
    if (eff_lock) begin
      has_grant = 1'b1;
      g_id      = eff_lk;
      for (int unsigned i = 0; i < N; i++) begin
        grant[i] = (eff_lk == IDW'(i));
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = 32'(eff_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!has_grant && in_valid[idx]) begin
          has_grant  = 1'b1;
          grant[idx] = 1'b1;
          g_id       = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        out_valid = out_valid | in_valid[i];
        out_last  = out_last  | in_last[i];
        out_data  = out_data  | in_data[i*NBITS +: NBITS];
      end
    end
  end

  assign in_ready  = grant & {N{out_ready & has_grant}};
  assign out_grant = grant;
  assign out_id    = g_id;
  assign xfer      = out_valid & out_ready;
  assign ptr_nxt   = (g_id == IDW'(N - 1)) ? '0 : g_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr  <= '0;
      lock <= 1'b0;
      lk   <= '0;
    end else if (xfer) begin
      if (out_last) begin
        lock <= 1'b0;
        ptr  <= ptr_nxt;
      end else begin
        lock <= 1'b1;
        lk   <= g_id;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomized and directed bench for rr_arb_mux against a packet-level model.
module tb_rr_arb_mux;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [3:0]    in_valid, in_last, in_ready, out_grant;
  logic [4*NB-1:0] in_data;
  logic          out_valid, out_last, out_ready;
  logic [NB-1:0] out_data;
  logic [1:0]    out_id;

  logic          v1, l1, r1, rdy1, ov1, ol1;
  logic [15:0]   d1, od1;
  logic [0:0]    g1, id1;

  int checks = 0;
  int errors = 0;

  // reference state
  int m_ptr  = 0;
  int m_lk   = 0;
  bit m_lock = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.N(4), .NBITS(NB)) u_dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .out_grant(out_grant), .out_id(out_id)
  );

  rr_arb_mux #(.N(1), .NBITS(16)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .in_valid(v1), .in_data(d1), .in_last(l1), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_ready(r1),
    .out_grant(g1), .out_id(id1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Granted channel from the rules, or -1 when idle.
  function automatic int model_grant();
    int p, g;
    if (resetn && m_lock) return m_lk;
    p = resetn ? m_ptr : 0;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && in_valid[(p + k) % 4]) g = (p + k) % 4;
    end
    return g;
  endfunction

  task automatic cycle(input int want_id);
    int g;
    logic [3:0] eg, er;
    logic ev, el;
    logic [NB-1:0] ed;
    @(negedge clk);
    g  = model_grant();
    eg = (g >= 0) ? 4'(1 << g) : 4'h0;
    er = out_ready ? eg : 4'h0;
    ev = (g >= 0) ? in_valid[g] : 1'b0;
    el = (g >= 0) ? in_last[g] : 1'b0;
    ed = (g >= 0) ? in_data[g*NB +: NB] : '0;
    check("grant", 64'(out_grant), 64'(eg));
    check("id", 64'(out_id), 64'((g >= 0) ? g : 0));
    check("valid", 64'(out_valid), 64'(ev));
    check("last", 64'(out_last), 64'(el));
    check("data", 64'(out_data), 64'(ed));
    check("ready", 64'(in_ready), 64'(er));
    if (want_id >= 0) check("dir_id", 64'(out_id), 64'(want_id));
    @(posedge clk);
    if (!resetn) begin
      m_ptr = 0; m_lock = 0; m_lk = 0;
    end else if (g >= 0 && in_valid[g] && out_ready) begin
      if (in_last[g]) begin
        m_lock = 0; m_ptr = (g + 1) % 4;
      end else begin
        m_lock = 1; m_lk = g;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    in_data   = $urandom;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(4'h0, 4'h0, 1'b0);
    cycle(0);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    v1 = 0; l1 = 0; r1 = 0; d1 = '0;
    drive(4'h0, 4'h0, 1'b0);
    cycle(0);
    cycle(0);
    resetn = 1'b1;

    // full load, single-beat packets: strict rotation
    drive(4'hF, 4'hF, 1'b1);
    for (int k = 0; k < 8; k++) cycle(k % 4);

    // 3-beat packet on ch1 with ch0/ch2 competing
    do_reset();
    drive(4'b0001, 4'b0001, 1'b1); cycle(0);
    drive(4'b0111, 4'b0101, 1'b1); cycle(1); cycle(1);
    drive(4'b0111, 4'b0111, 1'b1); cycle(1);
    cycle(2);

    // locked channel drops valid; ch3 must wait
    do_reset();
    drive(4'b0001, 4'b0001, 1'b1); cycle(0);
    drive(4'b0010, 4'b0000, 1'b1); cycle(1);
    drive(4'b1000, 4'b0000, 1'b1); cycle(1); cycle(1);
    drive(4'b1010, 4'b0010, 1'b1); cycle(1);
    cycle(3);

    // backpressure holds grant and pointer
    do_reset();
    drive(4'b0100, 4'b0100, 1'b0);
    for (int k = 0; k < 5; k++) cycle(2);
    drive(4'b0100, 4'b0100, 1'b1); cycle(2);
    drive(4'b1111, 4'b1111, 1'b0); cycle(3);

    // reset mid-packet clears the lock
    do_reset();
    drive(4'b1000, 4'b0000, 1'b1); cycle(3);
    resetn = 1'b0;
    drive(4'b1001, 4'b0000, 1'b1); cycle(0);
    resetn = 1'b1;
    cycle(0);
    cycle(0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      resetn = ($urandom_range(0, 49) != 0);
      drive(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
      cycle(-1);
    end

    // single-channel instance, 2-beat packet
    resetn = 1'b1;
    v1 = 1; l1 = 0; d1 = 16'hABCD; r1 = 0;
    @(negedge clk);
    check("n1_ready0", 64'(rdy1), 64'(0));
    check("n1_data0", 64'(od1), 64'(16'hABCD));
    check("n1_id0", 64'(id1), 64'(0));
    @(posedge clk); #1;
    r1 = 1;
    @(negedge clk);
    check("n1_ready1", 64'(rdy1), 64'(1));
    check("n1_data1", 64'(od1), 64'(16'hABCD));
    check("n1_last1", 64'(ol1), 64'(0));
    @(posedge clk); #1;
    v1 = 0;
    @(negedge clk);
    check("n1_lockgrant", 64'(g1), 64'(1));
    check("n1_lockvalid", 64'(ov1), 64'(0));
    @(posedge clk); #1;
    v1 = 1; l1 = 1; d1 = 16'h1234;
    @(negedge clk);
    check("n1_data2", 64'(od1), 64'(16'h1234));
    check("n1_last2", 64'(ol1), 64'(1));
    check("n1_valid2", 64'(ov1), 64'(1));
    check("n1_id2", 64'(id1), 64'(0));
    @(posedge clk); #1;
    r1 = 0;
    @(negedge clk);
    check("n1_ready_off", 64'(rdy1), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N, default 2, number of input channels (N >= 1).
REQ-002 Parameter NBITS, default 8, payload width per channel.
REQ-003 Parameter IDW, default max(1, $clog2(N)), width of grant index.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  N  per-channel valid.
REQ-007 in_data  input  N*NBITS  channel i payload at bits [i*NBITS +: NBITS].
REQ-008 in_last  input  N  per-channel last-beat-of-packet flag.
REQ-009 in_ready  output  N  per-channel ready; one-hot or zero.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_data  output  NBITS  payload of granted channel.
REQ-012 out_last  output  1  last flag of granted channel.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_grant  output  N  one-hot current grant, zero when idle.
REQ-015 out_id  output  IDW  binary index of granted channel, 0 when idle.

Function
REQ-016 State: pointer ptr (IDW bits, range 0..N-1), lock flag, locked index lk (IDW bits).
REQ-017 Unlocked: grant the first channel with in_valid=1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (round-robin, wrap at N).
REQ-018 Unlocked with no in_valid: out_grant=0, out_id=0, out_valid=0.
REQ-019 Locked: grant is channel lk regardless of other valids, including when in_valid[lk]=0.
REQ-020 out_valid = in_valid[g]; out_data = in_data of g; out_last = in_last[g]; g = granted channel; all combinational, zero latency.
REQ-021 in_ready[g] = out_ready when a grant exists; all other in_ready bits 0.
REQ-022 Transfer = out_valid & out_ready.
REQ-023 Transfer with out_last=0: next cycle lock=1, lk=g; ptr unchanged.
REQ-024 Transfer with out_last=1: next cycle lock=0, ptr = (g+1) mod N.
REQ-025 No transfer: ptr, lock, lk unchanged; no grant switch while locked.
REQ-026 Unlocked, no transfer: grant may change between cycles as in_valid changes (no commitment before first beat).
REQ-027 N=1: ptr stays 0; channel 0 always granted when valid; lock still tracked.
REQ-028 Single-beat packets (in_last=1) never set lock.
REQ-029 out_ready=0 never alters state; payload passes through unchanged.

Reset
REQ-030 resetn=0 at rising edge: ptr=0, lock=0, lk=0.
REQ-031 During and one cycle after reset, outputs are a function of inputs with ptr=0, unlocked; no state advance on reset cycles.
REQ-032 Reset mid-packet clears lock; next grant is from ptr=0 search.

Verification
REQ-033 N=4, all valid, all last=1, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3.
REQ-034 N=4, ch1 sends 3-beat packet (last on beat 3) while ch0, ch2 valid -> out_id 1,1,1 then 2; ch0 in_ready=0 throughout.
REQ-035 Locked on ch1, in_valid[1] dropped 2 cycles with ch3 valid -> out_grant=0010, out_valid=0, ch3 not granted until ch1 last beat.
REQ-036 ch2 valid, out_ready=0 for 5 cycles -> in_ready=0000, out_id=2 held, ptr unchanged; out_ready=1 -> one transfer, ptr=3.
REQ-037 Reset asserted while locked on ch3 mid-packet, ch0 and ch3 valid after reset -> out_id=0, lock=0.
REQ-038 N=1, NBITS=16, 2-beat packet 0xABCD, 0x1234 -> out_data matches, in_ready=out_ready, out_id=0.
